// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED bar light show.
// Provides the phase and command encodings, the kickback/full bar values
// and per-phase lookups (command, target value, successor phase).
package led_seq_pkg;

    localparam int unsigned BAR_W   = 16;
    localparam int unsigned PHASE_W = 4;

    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE = 4'd0,
        PH_UP1  = 4'd1,
        PH_DN1  = 4'd2,
        PH_UP2  = 4'd3,
        PH_DN2  = 4'd4,
        PH_UP3  = 4'd5,
        PH_DN3  = 4'd6,
        PH_KB2  = 4'd7,
        PH_KB3  = 4'd8
    } phase_e;

    typedef enum logic [1:0] {
        CMD_HOLD   = 2'd0,
        CMD_GROW   = 2'd1,
        CMD_SHRINK = 2'd2,
        CMD_CLEAR  = 2'd3
    } cmd_e;

    localparam logic [BAR_W-1:0] KB5  = 16'h001F;
    localparam logic [BAR_W-1:0] KB10 = 16'h03FF;
    localparam logic [BAR_W-1:0] FULL = 16'hFFFF;

    // Bar command issued while a phase has not yet reached its target.
    function automatic cmd_e phase_cmd(input logic [PHASE_W-1:0] p);
        case (p)
            PH_UP1, PH_UP2, PH_UP3:                 return CMD_GROW;
            PH_DN1, PH_DN2, PH_DN3, PH_KB2, PH_KB3: return CMD_SHRINK;
            default:                                return CMD_HOLD;
        endcase
    endfunction

    // Bar value at which a phase hands over to its successor.
    function automatic logic [BAR_W-1:0] phase_target(input logic [PHASE_W-1:0] p);
        case (p)
            PH_UP1, PH_DN2, PH_KB3: return KB5;
            PH_UP2:                 return KB10;
            PH_UP3:                 return FULL;
            default:                return '0;
        endcase
    endfunction

    // Successor phase once the target is reached.
    function automatic logic [PHASE_W-1:0] phase_next(input logic [PHASE_W-1:0] p);
        case (p)
            PH_UP1:  return PH_DN1;
            PH_DN1:  return PH_UP2;
            PH_UP2:  return PH_DN2;
            PH_DN2:  return PH_UP3;
            PH_UP3:  return PH_DN3;
            PH_KB2:  return PH_UP2;
            PH_KB3:  return PH_UP3;
            default: return PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/led_bar_shifter.sv
// led_bar_shifter: thermometer-coded LED bar register.
// Ports: clk, reset (sync, active-low), en (apply cmd this cycle),
//        cmd (HOLD/GROW/SHRINK/CLEAR), out (16-bit bar, filled from bit 0).
module led_bar_shifter
    import led_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  cmd_e             cmd,
    output logic [BAR_W-1:0] out
);

    // Apply the bar command on enabled cycles only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out <= '0;
        end else if (en) begin
            case (cmd)
                CMD_GROW:   out <= {out[BAR_W-2:0], 1'b1};
                CMD_SHRINK: out <= {1'b0, out[BAR_W-1:1]};
                CMD_CLEAR:  out <= '0;
                default:    out <= out;
            endcase
        end
    end

endmodule

// File: rtl/led_phase_scheduler.sv
// led_phase_scheduler: drives the LED bar through its fixed light show.
// Ports: clk, reset (sync, active-low), flick (raw async button),
//        out (16-bit LED bar), phase (current phase code),
//        busy (phase != IDLE), done (one-cycle pulse at end of show).
// DIV sets clock cycles per show step.
module led_phase_scheduler
    import led_seq_pkg::*;
#(
    parameter int unsigned DIV = 25_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flick,
    output logic [BAR_W-1:0]   out,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic               done
);

    localparam int unsigned    CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0]   cnt_q;
    logic               step_c;
    logic               sync1, sync2, sync3, rise_q, pend;
    logic [PHASE_W-1:0] phase_d;
    cmd_e               cmd_c;
    logic               done_d;
    logic               kb_point_c;

    // Step prescaler: one step per DIV cycles.
    assign step_c = (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!reset)      cnt_q <= '0;
        else if (step_c) cnt_q <= '0;
        else             cnt_q <= cnt_q + CNT_W'(1);
    end

    // Button synchronizer, registered rising-edge detect and pending latch.
    // A fresh edge beats the per-step clear so a coincident press is kept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            rise_q <= 1'b0;
            pend   <= 1'b0;
        end else begin
            sync1  <= flick;
            sync2  <= sync1;
            sync3  <= sync2;
            rise_q <= sync2 & ~sync3;
            if (rise_q)      pend <= 1'b1;
            else if (step_c) pend <= 1'b0;
        end
    end

    // Phase state register: advances on step cycles only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= PH_IDLE;
            done  <= 1'b0;
        end else begin
            if (step_c) phase <= phase_d;
            done <= step_c & done_d;
        end
    end

    assign kb_point_c = (out == KB5) || (out == KB10);

    // Next phase and bar command; kickback is checked before target match.
    always_comb begin
        phase_d = phase;
        cmd_c   = CMD_HOLD;
        done_d  = 1'b0;
        case (phase)
            PH_IDLE: begin
                if (pend) begin
                    phase_d = PH_UP1;
                    cmd_c   = CMD_CLEAR;
                end
            end
            PH_UP1, PH_DN1, PH_UP2, PH_DN2, PH_UP3, PH_DN3, PH_KB2, PH_KB3: begin
                if ((phase == PH_UP2 || phase == PH_UP3) && kb_point_c && pend) begin
                    phase_d = (phase == PH_UP2) ? PH_KB2 : PH_KB3;
                end else if (out == phase_target(phase)) begin
                    phase_d = phase_next(phase);
                    done_d  = (phase == PH_DN3);
                end else begin
                    cmd_c = phase_cmd(phase);
                end
            end
            default: begin
                phase_d = PH_IDLE;
                cmd_c   = CMD_CLEAR;
            end
        endcase
    end

    assign busy = (phase != PH_IDLE);

    led_bar_shifter u_bar (
        .clk   (clk),
        .reset (reset),
        .en    (step_c),
        .cmd   (cmd_c),
        .out   (out)
    );

endmodule

// File: tb/tb_led_phase_scheduler.sv
// tb_led_phase_scheduler: checks two schedulers (DIV=1 and DIV=4) sharing
// button and reset against a lamp-count reference model of the light show.
module tb_led_phase_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        flick;
    logic [15:0] out1, out4;
    logic [3:0]  ph1, ph4;
    logic        busy1, busy4, done1, done4;

    always #5 clk = ~clk;

    led_phase_scheduler #(.DIV(1)) dut1 (
        .clk(clk), .reset(reset), .flick(flick),
        .out(out1), .phase(ph1), .busy(busy1), .done(done1)
    );

    led_phase_scheduler #(.DIV(4)) dut4 (
        .clk(clk), .reset(reset), .flick(flick),
        .out(out4), .phase(ph4), .busy(busy4), .done(done4)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference state per instance: lamp count instead of bar pattern.
    int       divs [2] = '{1, 4};
    int       m_cnt[2];
    int       m_n  [2];
    int       m_ph [2];
    bit       m_pend[2];
    bit       m_done[2];
    bit [3:0] m_h  [2];   // raw button samples from previous edges, [0] newest

    function automatic logic [15:0] lamps(input int n);
        logic [31:0] v;
        v = (32'd1 << n) - 32'd1;
        return v[15:0];
    endfunction

    // One clock edge of the show rules for instance k.
    task automatic model_edge(input int k, input bit f, input bit rn);
        bit stp, rise, pd, kb;
        int n, ph;
        if (!rn) begin
            m_cnt[k] = 0; m_n[k] = 0; m_ph[k] = 0;
            m_pend[k] = 0; m_done[k] = 0; m_h[k] = '0;
            return;
        end
        stp      = (m_cnt[k] == divs[k] - 1);
        m_cnt[k] = stp ? 0 : m_cnt[k] + 1;
        // press sampled three edges ago after a low sample four edges ago
        rise     = m_h[k][2] & ~m_h[k][3];
        m_h[k]   = {m_h[k][2:0], f};
        pd        = m_pend[k];
        m_pend[k] = rise | (pd & !stp);
        m_done[k] = 0;
        if (stp) begin
            n  = m_n[k];
            ph = m_ph[k];
            kb = pd && (n == 5 || n == 10);
            case (ph)
                0: if (pd) begin ph = 1; n = 0; end
                1: if (n == 5)  ph = 2; else n++;
                2: if (n == 0)  ph = 3; else n--;
                3: if (kb) ph = 7; else if (n == 10) ph = 4; else n++;
                4: if (n == 5)  ph = 5; else n--;
                5: if (kb) ph = 8; else if (n == 16) ph = 6; else n++;
                6: if (n == 0) begin ph = 0; m_done[k] = 1; end else n--;
                7: if (n == 0)  ph = 3; else n--;
                8: if (n == 5)  ph = 5; else n--;
                default: begin ph = 0; n = 0; end
            endcase
            m_n[k]  = n;
            m_ph[k] = ph;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input bit f);
        flick = f;
        @(posedge clk);
        model_edge(0, f, reset);
        model_edge(1, f, reset);
        #1;
        check("out_div1",   32'(out1),  32'(lamps(m_n[0])));
        check("phase_div1", 32'(ph1),   32'(m_ph[0]));
        check("busy_div1",  32'(busy1), 32'(m_ph[0] != 0));
        check("done_div1",  32'(done1), 32'(m_done[0]));
        check("out_div4",   32'(out4),  32'(lamps(m_n[1])));
        check("phase_div4", 32'(ph4),   32'(m_ph[1]));
        check("busy_div4",  32'(busy4), 32'(m_ph[1] != 0));
        check("done_div4",  32'(done4), 32'(m_done[1]));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cycle(1'b0);
    endtask

    // Advance until the DIV=1 model is in phase p with n lamps lit.
    task automatic wait_for(input string tag, input int p, input int n);
        int budget;
        budget = 600;
        while (!(m_ph[0] == p && m_n[0] == n) && budget > 0) begin
            cycle(1'b0);
            budget--;
        end
        if (budget == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed timeout expected phase %0d lamps %0d", tag, p, n);
        end
    endtask

    initial begin
        reset = 1'b0;
        flick = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0);
        reset = 1'b1;

        // No press: both stay idle and dark.
        run(24);

        // Full show; DIV=1 finishes within 70 cycles, DIV=4 within 300.
        cycle(1'b1);
        run(300);

        // Kickback in UP2 at 5 lamps, then at 10 lamps.
        cycle(1'b1);
        wait_for("reach_up2_1", 3, 1);
        cycle(1'b1);
        run(4);
        check("kb2_at_5", 32'(ph1), 32'd7);
        wait_for("reach_up2_6", 3, 6);
        cycle(1'b1);
        run(4);
        check("kb2_at_10", 32'(ph1), 32'd7);

        // Kickback in UP3 at 10 lamps, then let the show finish.
        wait_for("reach_up3_6", 5, 6);
        cycle(1'b1);
        run(4);
        check("kb3_at_10", 32'(ph1), 32'd8);
        run(400);

        // Press during DN1 is discarded.
        cycle(1'b1);
        wait_for("reach_dn1_4", 2, 4);
        cycle(1'b1);
        run(400);

        // Reset mid-UP3 with a stale press in the synchronizer.
        cycle(1'b1);
        wait_for("reach_up3_8", 5, 8);
        cycle(1'b1);
        reset = 1'b0;
        cycle(1'b0);
        reset = 1'b1;
        check("reset_out",   32'(out1),  32'd0);
        check("reset_phase", 32'(ph1),   32'd0);
        run(60);
        check("stale_idle",  32'(ph1),   32'd0);

        // Random presses with rare resets.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 999) != 0);
            cycle($urandom_range(0, 15) == 0);
        end
        reset = 1'b1;
        run(300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
